// File: rtl/uart_pkg.sv
// Shared FSM encodings and helpers for the uart_link UART engine.
// The PARITY encodings are only reached when UART_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   localparam int unsigned MAX_D_W = 9;

   // Zero-extension to MAX_D_W does not change the XOR reduction.
   function automatic logic parity_bit(input logic [MAX_D_W-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy output.
// Full-push and empty-pop are ignored; pointers wrap modulo DEPTH.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter  int unsigned D_W   = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned LVL_W = level_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [D_W-1:0]   wr_data_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   output logic [D_W-1:0]   rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic [LVL_W-1:0] level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [D_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] cnt_q;
   logic             push;
   logic             pop;

   assign wr_ready_o = (cnt_q != LVL_W'(DEPTH));
   assign rd_valid_o = (cnt_q != '0);
   assign push       = wr_valid_i && wr_ready_o;
   assign pop        = rd_ready_i && rd_valid_o;
   assign rd_data_o  = mem_q[rd_ptr_q];
   assign level_o    = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + LVL_W'(1);
            2'b01:   cnt_q <= cnt_q - LVL_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_link.sv
// Full-duplex UART: runtime baud divisor, TX/RX FIFOs, 16x-style oversampled RX, sticky errors.
// Define UART_PARITY_EN to build parity generation/checking; otherwise cfg_par_* are ignored.
module uart_link
   import uart_pkg::*;
#(
   parameter  int unsigned D_W    = 8,
   parameter  int unsigned DEPTH  = 16,
   parameter  int unsigned B_TICK = 16,
   parameter  int unsigned DIV_W  = 16,
   localparam int unsigned LVL_W  = level_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_stop2,
   input  logic             cfg_par_en,
   input  logic             cfg_par_odd,
   input  logic [D_W-1:0]   tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [D_W-1:0]   rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             txd,
   input  logic             rxd,
   output logic             tx_busy,
   input  logic             err_clr,
   output logic             rx_frame_err,
   output logic             rx_par_err,
   output logic             rx_overrun,
   output logic [LVL_W-1:0] tx_level,
   output logic [LVL_W-1:0] rx_level
);

   localparam int unsigned TCNT_W = $clog2(2 * B_TICK);
   localparam int unsigned BCNT_W = $clog2(D_W);
   localparam logic [TCNT_W-1:0] BIT_LAST   = TCNT_W'(B_TICK - 1);
   localparam logic [TCNT_W-1:0] STOP2_LAST = TCNT_W'(2 * B_TICK - 1);
   localparam logic [TCNT_W-1:0] HALF_LAST  = TCNT_W'(B_TICK / 2 - 1);
   localparam logic [BCNT_W-1:0] DATA_LAST  = BCNT_W'(D_W - 1);

   // ---------------- baud tick generator ----------------
   logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   always_comb begin
      tick       = (baud_cnt_q == div_q);
      baud_cnt_d = baud_cnt_q + DIV_W'(1);
      div_d      = div_q;
      if (tick) begin
         baud_cnt_d = '0;
         div_d      = cfg_div;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_cnt_q <= '0;
         div_q      <= '0;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
      end
   end

   // ---------------- TX path ----------------
   logic [D_W-1:0] tx_fifo_data;
   logic           tx_fifo_valid;
   logic           tx_pop;

   uart_sync_fifo #(.D_W(D_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk_i      (clk),
      .rst_ni     (rst),
      .wr_data_i  (tx_data),
      .wr_valid_i (tx_valid),
      .wr_ready_o (tx_ready),
      .rd_data_o  (tx_fifo_data),
      .rd_valid_o (tx_fifo_valid),
      .rd_ready_i (tx_pop),
      .level_o    (tx_level)
   );

   tx_state_e         tx_state_q, tx_state_d;
   logic [TCNT_W-1:0] tx_tcnt_q, tx_tcnt_d;
   logic [BCNT_W-1:0] tx_bcnt_q, tx_bcnt_d;
   logic [D_W-1:0]    tx_shift_q, tx_shift_d;
   logic              tx_stop2_q, tx_stop2_d;
   logic              txd_q, txd_d;
   logic              tx_par_en_q, tx_par_en_d;
   logic              tx_par_q, tx_par_d;
   logic              tx_bit_end, tx_stop_end, tx_load;

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_tcnt_d   = tick ? tx_tcnt_q + TCNT_W'(1) : tx_tcnt_q;
      tx_bcnt_d   = tx_bcnt_q;
      tx_shift_d  = tx_shift_q;
      tx_stop2_d  = tx_stop2_q;
      tx_par_en_d = tx_par_en_q;
      tx_par_d    = tx_par_q;
      tx_load     = 1'b0;
      tx_bit_end  = tick && (tx_tcnt_q == BIT_LAST);
      tx_stop_end = tick && (tx_tcnt_q == (tx_stop2_q ? STOP2_LAST : BIT_LAST));

      case (tx_state_q)
         TX_IDLE:  tx_load = tick && tx_fifo_valid;
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_tcnt_d  = '0;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_tcnt_d  = '0;
               tx_shift_d = tx_shift_q >> 1;
               tx_bcnt_d  = tx_bcnt_q + BCNT_W'(1);
               if (tx_bcnt_q == DATA_LAST) begin
                  tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
               end
            end
         end
`ifdef UART_PARITY_EN
         TX_PARITY: begin
            if (tx_bit_end) begin
               tx_state_d = TX_STOP;
               tx_tcnt_d  = '0;
            end
         end
`endif
         TX_STOP: begin
            // A queued word starts straight from STOP so frames run back to back.
            if (tx_stop_end) begin
               tx_load    = tx_fifo_valid;
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      if (tx_load) begin
         tx_state_d = TX_START;
         tx_tcnt_d  = '0;
         tx_bcnt_d  = '0;
         tx_shift_d = tx_fifo_data;
         tx_stop2_d = cfg_stop2;
`ifdef UART_PARITY_EN
         tx_par_en_d = cfg_par_en;
         tx_par_d    = parity_bit(MAX_D_W'(tx_fifo_data), cfg_par_odd);
`else
         tx_par_en_d = 1'b0;
         tx_par_d    = 1'b0;
`endif
      end
      tx_pop = tx_load;

      case (tx_state_d)
         TX_START:  txd_d = 1'b0;
         TX_DATA:   txd_d = tx_shift_d[0];
         TX_PARITY: txd_d = tx_par_d;
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q  <= TX_IDLE;
         tx_tcnt_q   <= '0;
         tx_bcnt_q   <= '0;
         tx_shift_q  <= '0;
         tx_stop2_q  <= 1'b0;
         tx_par_en_q <= 1'b0;
         tx_par_q    <= 1'b0;
         txd_q       <= 1'b1;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_tcnt_q   <= tx_tcnt_d;
         tx_bcnt_q   <= tx_bcnt_d;
         tx_shift_q  <= tx_shift_d;
         tx_stop2_q  <= tx_stop2_d;
         tx_par_en_q <= tx_par_en_d;
         tx_par_q    <= tx_par_d;
         txd_q       <= txd_d;
      end
   end

   assign txd     = txd_q;
   assign tx_busy = (tx_state_q != TX_IDLE) || tx_fifo_valid;

   // ---------------- RX path ----------------
   logic [1:0]        rx_sync_q;
   logic              rxs;
   rx_state_e         rx_state_q, rx_state_d;
   logic [TCNT_W-1:0] rx_tcnt_q, rx_tcnt_d;
   logic [BCNT_W-1:0] rx_bcnt_q, rx_bcnt_d;
   logic [D_W-1:0]    rx_shift_q, rx_shift_d;
   logic              rx_brk_q, rx_brk_d;
   logic              rx_par_en_q, rx_par_en_d;
   logic              rx_par_odd_q, rx_par_odd_d;
   logic              rx_par_bit_q, rx_par_bit_d;
   logic              frame_err_q, frame_err_d;
   logic              par_err_q, par_err_d;
   logic              overrun_q, overrun_d;
   logic              rx_bit_end, rx_push, rx_fifo_ready;
   logic              set_frame, set_par, set_ovr;

   assign rxs = rx_sync_q[1];

   uart_sync_fifo #(.D_W(D_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk_i      (clk),
      .rst_ni     (rst),
      .wr_data_i  (rx_shift_q),
      .wr_valid_i (rx_push),
      .wr_ready_o (rx_fifo_ready),
      .rd_data_o  (rx_data),
      .rd_valid_o (rx_valid),
      .rd_ready_i (rx_ready),
      .level_o    (rx_level)
   );

   always_comb begin
      rx_state_d   = rx_state_q;
      rx_tcnt_d    = tick ? rx_tcnt_q + TCNT_W'(1) : rx_tcnt_q;
      rx_bcnt_d    = rx_bcnt_q;
      rx_shift_d   = rx_shift_q;
      rx_brk_d     = rx_brk_q;
      rx_par_en_d  = rx_par_en_q;
      rx_par_odd_d = rx_par_odd_q;
      rx_par_bit_d = rx_par_bit_q;
      rx_push      = 1'b0;
      set_frame    = 1'b0;
      set_par      = 1'b0;
      set_ovr      = 1'b0;
      rx_bit_end   = tick && (rx_tcnt_q == BIT_LAST);

      case (rx_state_q)
         RX_IDLE: begin
            // After a framing error the line must return high before re-arming.
            if (rx_brk_q) begin
               if (rxs) rx_brk_d = 1'b0;
            end else if (tick && !rxs) begin
               rx_state_d = RX_START;
               rx_tcnt_d  = '0;
`ifdef UART_PARITY_EN
               rx_par_en_d  = cfg_par_en;
               rx_par_odd_d = cfg_par_odd;
`endif
            end
         end
         RX_START: begin
            if (tick && rx_tcnt_q == HALF_LAST) begin
               rx_tcnt_d  = '0;
               rx_bcnt_d  = '0;
               rx_state_d = rxs ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_tcnt_d  = '0;
               rx_shift_d = {rxs, rx_shift_q[D_W-1:1]};
               rx_bcnt_d  = rx_bcnt_q + BCNT_W'(1);
               if (rx_bcnt_q == DATA_LAST) begin
                  rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
               end
            end
         end
`ifdef UART_PARITY_EN
         RX_PARITY: begin
            if (rx_bit_end) begin
               rx_tcnt_d    = '0;
               rx_par_bit_d = rxs;
               rx_state_d   = RX_STOP;
            end
         end
`endif
         RX_STOP: begin
            if (rx_bit_end) begin
               rx_tcnt_d  = '0;
               rx_state_d = RX_IDLE;
               if (!rxs) begin
                  set_frame = 1'b1;
                  rx_brk_d  = 1'b1;
               end else if (rx_par_en_q &&
                            (rx_par_bit_q != parity_bit(MAX_D_W'(rx_shift_q), rx_par_odd_q))) begin
                  set_par = 1'b1;
               end else if (!rx_fifo_ready) begin
                  set_ovr = 1'b1;
               end else begin
                  rx_push = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase

      frame_err_d = set_frame || (frame_err_q && !err_clr);
      par_err_d   = set_par   || (par_err_q   && !err_clr);
      overrun_d   = set_ovr   || (overrun_q   && !err_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_sync_q    <= 2'b11;
         rx_state_q   <= RX_IDLE;
         rx_tcnt_q    <= '0;
         rx_bcnt_q    <= '0;
         rx_shift_q   <= '0;
         rx_brk_q     <= 1'b0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
         rx_par_bit_q <= 1'b0;
         frame_err_q  <= 1'b0;
         par_err_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         rx_sync_q    <= {rx_sync_q[0], rxd};
         rx_state_q   <= rx_state_d;
         rx_tcnt_q    <= rx_tcnt_d;
         rx_bcnt_q    <= rx_bcnt_d;
         rx_shift_q   <= rx_shift_d;
         rx_brk_q     <= rx_brk_d;
         rx_par_en_q  <= rx_par_en_d;
         rx_par_odd_q <= rx_par_odd_d;
         rx_par_bit_q <= rx_par_bit_d;
         frame_err_q  <= frame_err_d;
         par_err_q    <= par_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_frame_err = frame_err_q;
   assign rx_overrun   = overrun_q;
`ifdef UART_PARITY_EN
   assign rx_par_err = par_err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{cfg_par_en, cfg_par_odd, par_err_q};
   assign rx_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link: TX framing, loopback, RX parity/framing/glitch, overrun, reset.
// Parity expectations follow whether UART_PARITY_EN is defined for the build.
module tb_uart_link;

   localparam int D_W     = 8;
   localparam int DEPTH   = 16;
   localparam int B_TICK  = 16;
   localparam int DIV_W   = 16;
   localparam int LVL_W   = 5;
   localparam int BIT_CLK = 64;
`ifdef UART_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [DIV_W-1:0] cfg_div = 16'd3;
   logic             cfg_stop2 = 1'b0;
   logic             cfg_par_en = 1'b0;
   logic             cfg_par_odd = 1'b0;
   logic [D_W-1:0]   tx_data = '0;
   logic             tx_valid = 1'b0;
   logic             tx_ready;
   logic [D_W-1:0]   rx_data;
   logic             rx_valid;
   logic             rx_ready = 1'b0;
   logic             txd;
   logic             rxd;
   logic             tx_busy;
   logic             err_clr = 1'b0;
   logic             rx_frame_err;
   logic             rx_par_err;
   logic             rx_overrun;
   logic [LVL_W-1:0] tx_level;
   logic [LVL_W-1:0] rx_level;
   logic             loop_en = 1'b0;
   logic             rxd_drv = 1'b1;

   int total = 0;
   int bad   = 0;

   assign rxd = loop_en ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart_link #(.D_W(D_W), .DEPTH(DEPTH), .B_TICK(B_TICK), .DIV_W(DIV_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_div      (cfg_div),
      .cfg_stop2    (cfg_stop2),
      .cfg_par_en   (cfg_par_en),
      .cfg_par_odd  (cfg_par_odd),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .txd          (txd),
      .rxd          (rxd),
      .tx_busy      (tx_busy),
      .err_clr      (err_clr),
      .rx_frame_err (rx_frame_err),
      .rx_par_err   (rx_par_err),
      .rx_overrun   (rx_overrun),
      .tx_level     (tx_level),
      .rx_level     (rx_level)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check(tag, rx_data, exp);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic wait_txd_low(input int budget);
      for (int n = 0; n < budget && txd !== 1'b0; n++) @(negedge clk);
   endtask

   task automatic wait_rx_level(input int lvl, input int budget);
      for (int n = 0; n < budget && rx_level != LVL_W'(lvl); n++) @(negedge clk);
   endtask

   // Samples a 1-stop, no-parity frame at mid-bit; frame[0] is the start bit.
   task automatic capture_tx(input string tag, input logic [9:0] exp);
      logic [9:0] frame;
      wait_txd_low(3000);
      check({tag, "_start_seen"}, txd, 1'b0);
      clks(BIT_CLK / 2);
      frame[0] = txd;
      for (int b = 1; b < 10; b++) begin
         clks(BIT_CLK);
         frame[b] = txd;
      end
      check({tag, "_frame"}, frame, exp);
      clks(30);
      check({tag, "_busy_in_stop"}, tx_busy, 1'b1);
      clks(4);
      check({tag, "_busy_after_stop"}, tx_busy, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_val,
                             input logic stop_val);
      rxd_drv = 1'b0;
      clks(BIT_CLK);
      for (int i = 0; i < D_W; i++) begin
         rxd_drv = d[i];
         clks(BIT_CLK);
      end
      if (with_par) begin
         rxd_drv = par_val;
         clks(BIT_CLK);
      end
      rxd_drv = stop_val;
      clks(BIT_CLK);
      rxd_drv = 1'b1;
      clks(BIT_CLK);
   endtask

   initial begin
      logic [7:0] d;

      // Reset values while rst is held low.
      clks(3);
      check("rst_txd", txd, 1'b1);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_frame_err", rx_frame_err, 1'b0);
      check("rst_par_err", rx_par_err, 1'b0);
      check("rst_overrun", rx_overrun, 1'b0);
      check("rst_tx_level", tx_level, 5'd0);
      check("rst_rx_level", rx_level, 5'd0);
      check("rst_tx_busy", tx_busy, 1'b0);
      rst = 1'b1;
      clks(4);

      // 8N1 frame of 0xA5.
      push_tx(8'hA5);
      capture_tx("tx_a5", {1'b1, 8'hA5, 1'b0});

      // Loopback, even parity, two stop bits.
      cfg_par_en  = 1'b1;
      cfg_par_odd = 1'b0;
      cfg_stop2   = 1'b1;
      loop_en     = 1'b1;
      push_tx(8'h00);
      push_tx(8'hFF);
      push_tx(8'h3C);
      wait_rx_level(3, 4000);
      check("loop_rx_level", rx_level, 5'd3);
      pop_check("loop_word0", 8'h00);
      pop_check("loop_word1", 8'hFF);
      pop_check("loop_word2", 8'h3C);
      check("loop_rx_valid_empty", rx_valid, 1'b0);
      check("loop_frame_err", rx_frame_err, 1'b0);
      check("loop_par_err", rx_par_err, 1'b0);
      check("loop_overrun", rx_overrun, 1'b0);
      for (int n = 0; n < 500 && tx_busy; n++) @(negedge clk);
      clks(10);
      loop_en = 1'b0;
      clks(BIT_CLK);

      // 0x81 with parity bit 1 under even parity.
      send_frame(8'h81, PAR_BUILT, 1'b1, 1'b1);
`ifdef UART_PARITY_EN
      check("par_err_set", rx_par_err, 1'b1);
      check("par_err_no_push", rx_level, 5'd0);
      pulse_clr();
      check("par_err_cleared", rx_par_err, 1'b0);
`else
      check("nopar_push", rx_level, 5'd1);
      check("nopar_par_err", rx_par_err, 1'b0);
      pop_check("nopar_word", 8'h81);
`endif

      // Stop bit driven low.
      send_frame(8'h55, PAR_BUILT, 1'b0, 1'b0);
      check("frame_err_set", rx_frame_err, 1'b1);
      check("frame_err_no_push", rx_level, 5'd0);
      pulse_clr();
      check("frame_err_cleared", rx_frame_err, 1'b0);

      // 20-clk low glitch, then a clean frame.
      rxd_drv = 1'b0;
      clks(20);
      rxd_drv = 1'b1;
      clks(100);
      check("glitch_no_push", rx_level, 5'd0);
      check("glitch_frame_err", rx_frame_err, 1'b0);
      check("glitch_par_err", rx_par_err, 1'b0);
      send_frame(8'hC3, PAR_BUILT, 1'b0, 1'b1);
      check("after_glitch_level", rx_level, 5'd1);
      pop_check("after_glitch_word", 8'hC3);

      // 17 frames into a 16-deep RX FIFO with no pops.
      for (int i = 1; i <= 17; i++) begin
         d = 8'(i);
         send_frame(d, PAR_BUILT, ^d, 1'b1);
      end
      check("ovr_rx_level", rx_level, 5'd16);
      check("ovr_flag", rx_overrun, 1'b1);
      check("ovr_frame_err", rx_frame_err, 1'b0);
      check("ovr_par_err", rx_par_err, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         d = 8'(i);
         pop_check($sformatf("ovr_pop%0d", i), d);
      end
      check("ovr_drained", rx_valid, 1'b0);
      pulse_clr();
      check("ovr_cleared", rx_overrun, 1'b0);

      // Reset in the middle of the DATA phase.
      cfg_par_en = 1'b0;
      cfg_stop2  = 1'b0;
      push_tx(8'h33);
      push_tx(8'h44);
      wait_txd_low(3000);
      check("rst_mid_start_seen", txd, 1'b0);
      clks(200);
      check("rst_mid_tx_level_before", tx_level, 5'd1);
      rst = 1'b0;
      #1;
      check("rst_mid_txd", txd, 1'b1);
      check("rst_mid_tx_level", tx_level, 5'd0);
      check("rst_mid_tx_busy", tx_busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      clks(4);
      push_tx(8'h5A);
      capture_tx("tx_5a", {1'b1, 8'h5A, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
